// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry {last,data} FIFO with occupancy count; head is visible combinationally.
module bram_stream_reader_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Reads LENGTH words from a 1-cycle-latency BRAM and streams them out (valid/ready, last).
// Optional BRAM_STREAM_READER_STRIDE_EN adds a stride input; otherwise stride is 1.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int W_DATA = 32,
    parameter int W_WORD = 4,
    parameter int W_LEN  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [W_WORD-1:0] base_addr,
    input  logic [W_LEN-1:0]  length,
`ifdef BRAM_STREAM_READER_STRIDE_EN
    input  logic [W_WORD-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [W_WORD-1:0] bram_addr,
    input  logic [W_DATA-1:0] bram_dout,
    output logic              m_valid,
    output logic [W_DATA-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output state_t            dbg_state
);

    // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // m_valid never drops and m_data/m_last never change until that happens.

    localparam logic [W_LEN-1:0] LEN_ONE = 1;

    state_t            state_q, state_d;
    logic [W_WORD-1:0] addr_q;
    logic [W_WORD-1:0] stride_q;
    logic [W_WORD-1:0] stride_w;
    logic [W_LEN-1:0]  len_q;
    logic [W_LEN-1:0]  issued_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              issue_last;
    logic              pop;
    logic [2:0]        occ;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [W_DATA:0]   fifo_head;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    assign stride_w = stride;
`else
    assign stride_w = {{(W_WORD-1){1'b0}}, 1'b1};
`endif

    assign pop        = m_valid & m_ready;
    assign issue_last = (issued_q == len_q - LEN_ONE);
    // Words buffered plus words still in the BRAM pipe, after this cycle's pop.
    assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d = state_q;
        bram_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (occ < 3'd2) begin
                    bram_en = 1'b1;
                    if (issue_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= bram_en;
            inflight_last_q <= bram_en & issue_last;
            if (state_q == ST_IDLE && start) begin
                addr_q   <= base_addr;
                stride_q <= stride_w;
                len_q    <= length;
                issued_q <= '0;
            end else if (bram_en) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + LEN_ONE;
            end
        end
    end

    bram_stream_reader_fifo #(
        .W (W_DATA + 1)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({inflight_last_q, bram_dout}),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign bram_we   = 1'b0;
    assign bram_addr = addr_q;
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[W_DATA-1:0];
    assign m_last    = !fifo_empty && fifo_head[W_DATA];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a BRAM model and a beat/address scoreboard.
module tb_bram_stream_reader;
    import bram_stream_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  length = '0;
    logic [3:0]  stride = 4'd1;
    logic        m_ready = 1'b0;
    logic [31:0] bram_dout;
    logic        busy, done, bram_en, bram_we, m_valid, m_last;
    logic [3:0]  bram_addr;
    logic [31:0] m_data;
    state_t      dbg_state;

    logic [31:0] mem [16];
    logic [32:0] exp_q [$];
    logic [3:0]  addr_exp_q [$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    bram_stream_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef BRAM_STREAM_READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bram_en"}, bram_en, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_we"}, bram_we, 0);
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low cycles 4..8 then random
    task automatic run_xfer(input int base, input int len, input int strd, input int mode,
                            input int abort_beats, input bit poke_start);
        int cyc = 0, beats = 0, done_cnt = 0, done_cyc = 0;
        int first_en = -1, last_en = -1, first_v = -1, first_beat = -1, last_beat = -1;
        bit stalled = 0;
        logic [31:0] stall_data = '0;
        logic [32:0] e;
        logic [3:0] a;
        for (int k = 0; k < len; k++) begin
            a = 4'(base + k * strd);
            addr_exp_q.push_back(a);
            exp_q.push_back({(k == len - 1), mem[a]});
        end
        @(negedge clk);
        start = 1'b1;
        base_addr = 4'(base);
        length = 5'(len);
        stride = 4'(strd);
        m_ready = (mode == 0);
        forever begin
            @(negedge clk);
            cyc++;
            start = poke_start && (cyc == 2);
            if (poke_start && cyc == 2) begin
                base_addr = 4'(base + 7);
                length = 5'd3;
            end
            case (mode)
                0: m_ready = 1'b1;
                2: m_ready = (cyc >= 4 && cyc <= 8) ? 1'b0 : 1'($urandom_range(0, 1));
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cyc == 1 && len > 0) check("busy_run", busy, 1);
            if (mode == 2 && cyc == 8) check("stall_no_issue", bram_en, 0);
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, stall_data);
            end
            if (bram_en) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                if (addr_exp_q.size() == 0) check("extra_read", 1, 0);
                else check("addr", bram_addr, addr_exp_q.pop_front());
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e[31:0]);
                    check("last", m_last, e[32]);
                end
            end
            stalled = m_valid && !m_ready;
            stall_data = m_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (abort_beats > 0 && beats == abort_beats) begin
                rstn = 1'b0;
                @(negedge clk);
                #1;
                check_idle_outputs("abort");
                rstn = 1'b1;
                m_ready = 1'b0;
                exp_q.delete();
                addr_exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("abort_no_done", done, 0);
                end
                return;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            if (cyc > 400) begin
                check("timeout", 0, 1);
                break;
            end
        end
        m_ready = 1'b0;
        check("done_once", done_cnt, 1);
        check("beats", beats, len);
        check("exp_empty", exp_q.size(), 0);
        check("addr_empty", addr_exp_q.size(), 0);
        if (mode == 0 && len > 0) begin
            check("lat_first_en", first_en, 1);
            check("lat_first_valid", first_v, 3);
            check("issue_back2back", last_en - first_en, len - 1);
            check("beat_back2back", last_beat - first_beat, len - 1);
        end
        exp_q.delete();
        addr_exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_state", dbg_state, ST_IDLE);
        rstn = 1'b1;

        run_xfer(3, 4, 1, 0, 0, 0);
        run_xfer(14, 4, 1, 0, 0, 0);
        run_xfer(9, 8, 1, 2, 0, 0);
        run_xfer(6, 5, 1, 1, 0, 1);
        run_xfer(2, 0, 1, 0, 0, 0);
        run_xfer(5, 6, 1, 0, 2, 0);
        run_xfer(11, 3, 1, 0, 0, 0);
        run_xfer(0, 31, 1, 1, 0, 0);
`ifdef BRAM_STREAM_READER_STRIDE_EN
        run_xfer(1, 4, 3, 0, 0, 0);
        run_xfer(7, 3, 0, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
